// File: rtl/lpc_frame_sequencer.sv
// Frame sequencer for the 11-lag autocorrelation datapath.
// Clears the correlator, streams FRAME_LEN samples into x and y, flushes the
// correlator pipeline with zero beats, then holds r_valid until r_ack.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start
// S_CLEAR | one-cycle synchronous clear of the correlator accumulators
// S_FEED  | accepting samples over s_valid/s_ready
// S_FLUSH | FLUSH_BEATS zero-valued advance beats
// S_DONE  | result held, waiting for r_ack
module lpc_frame_sequencer #(
  parameter int FRAME_LEN   = 240,
  parameter int FLUSH_BEATS = 3,
  parameter int CNT_W       = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [15:0]         c_x,
  output logic [15:0]         c_y,
  output logic                c_v,
  output logic                c_rst,
  output logic                busy,
  output logic                r_valid,
  input  logic                r_ack,
  output logic [CNT_W-1:0]    sample_cnt
);

  // Width holds FLUSH_BEATS down to zero; never collapses to zero bits.
  localparam int FW = $clog2(FLUSH_BEATS + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s_ready,  w_s_ready_nxt;
  logic [15:0]      r_c_data,   w_c_data_nxt;
  logic             r_c_v,      w_c_v_nxt;
  logic             r_c_rst,    w_c_rst_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_r_valid,  w_r_valid_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [FW-1:0]    r_flush,    w_flush_nxt;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == S_FEED) && s_valid && r_s_ready;
  assign w_last   = w_accept && (r_cnt == CNT_W'(FRAME_LEN - 1));

  // Next-state and next registered-output values; every output is a flop.
  always_comb begin
    w_state_nxt   = r_state;
    w_s_ready_nxt = 1'b0;
    w_c_data_nxt  = r_c_data;
    w_c_v_nxt     = 1'b0;
    w_c_rst_nxt   = 1'b0;
    w_r_valid_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_flush_nxt   = r_flush;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_CLEAR;
          w_c_rst_nxt  = 1'b1;
          w_cnt_nxt    = '0;
          w_c_data_nxt = '0;
        end
      end
      S_CLEAR: begin
        w_state_nxt   = S_FEED;
        w_s_ready_nxt = 1'b1;
      end
      S_FEED: begin
        w_s_ready_nxt = 1'b1;
        if (w_accept) begin
          w_c_data_nxt = s_data;
          w_c_v_nxt    = 1'b1;
          w_cnt_nxt    = r_cnt + CNT_W'(1);
        end
        // Ready drops together with the last accepted sample so no extra one slips in.
        if (w_last) begin
          w_s_ready_nxt = 1'b0;
          w_flush_nxt   = FW'(FLUSH_BEATS);
          w_state_nxt   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_flush == '0) begin
          w_state_nxt   = S_DONE;
          w_r_valid_nxt = 1'b1;
        end else begin
          w_c_v_nxt    = 1'b1;
          w_c_data_nxt = '0;
          w_flush_nxt  = r_flush - FW'(1);
        end
      end
      S_DONE: begin
        if (r_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_r_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_s_ready <= 1'b0;
      r_c_data  <= '0;
      r_c_v     <= 1'b0;
      r_c_rst   <= 1'b0;
      r_busy    <= 1'b0;
      r_r_valid <= 1'b0;
      r_cnt     <= '0;
      r_flush   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_c_data  <= w_c_data_nxt;
      r_c_v     <= w_c_v_nxt;
      r_c_rst   <= w_c_rst_nxt;
      r_busy    <= w_busy_nxt;
      r_r_valid <= w_r_valid_nxt;
      r_cnt     <= w_cnt_nxt;
      r_flush   <= w_flush_nxt;
    end
  end

  assign s_ready    = r_s_ready;
  assign c_x        = r_c_data;
  assign c_y        = r_c_data;
  assign c_v        = r_c_v;
  assign c_rst      = r_c_rst;
  assign busy       = r_busy;
  assign r_valid    = r_r_valid;
  assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_lpc_frame_sequencer.sv
// Scoreboard bench for lpc_frame_sequencer: instance A (FRAME_LEN=240) is
// checked by a beat monitor against a queue of expected correlator inputs;
// instance B (FRAME_LEN=2) covers the sample-count boundary directly.
module tb_lpc_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_start = 0, a_s_valid = 0, a_r_ack = 0;
  logic [15:0] a_s_data = 0;
  logic        a_s_ready, a_c_v, a_c_rst, a_busy, a_r_valid;
  logic [15:0] a_c_x, a_c_y;
  logic [11:0] a_cnt;

  logic        b_start = 0, b_s_valid = 0, b_r_ack = 0;
  logic [15:0] b_s_data = 0;
  logic        b_s_ready, b_c_v, b_c_rst, b_busy, b_r_valid;
  logic [15:0] b_c_x, b_c_y;
  logic [11:0] b_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_crst   = 0;
  logic [15:0] q[$];

  lpc_frame_sequencer #(.FRAME_LEN(240), .FLUSH_BEATS(3), .CNT_W(12)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .s_data(a_s_data), .s_valid(a_s_valid),
    .s_ready(a_s_ready), .c_x(a_c_x), .c_y(a_c_y), .c_v(a_c_v), .c_rst(a_c_rst),
    .busy(a_busy), .r_valid(a_r_valid), .r_ack(a_r_ack), .sample_cnt(a_cnt));

  lpc_frame_sequencer #(.FRAME_LEN(2), .FLUSH_BEATS(3), .CNT_W(12)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .s_data(b_s_data), .s_valid(b_s_valid),
    .s_ready(b_s_ready), .c_x(b_c_x), .c_y(b_c_y), .c_v(b_c_v), .c_rst(b_c_rst),
    .busy(b_busy), .r_valid(b_r_valid), .r_ack(b_r_ack), .sample_cnt(b_cnt));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every correlator beat on A must match the next queued sample.
  always @(negedge clk) begin
    check("crst_cv_exclusive", longint'(a_c_rst & a_c_v), 0);
    if (a_c_rst) n_crst++;
    if (a_c_v) begin
      if (q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        logic [15:0] e;
        e = q.pop_front();
        check("beat_c_x", $signed(a_c_x), $signed(e));
        check("beat_c_y", $signed(a_c_y), $signed(e));
      end
    end
  end

  // Constant-valued 240-sample frame with s_valid held high; start is
  // re-pulsed mid-frame and must be ignored.
  task automatic frame_const(input logic [15:0] d);
    int  i;
    bit  seen;
    for (int k = 0; k < 240; k++) q.push_back(d);
    repeat (3) q.push_back(16'h0000);
    @(posedge clk); #1 a_start = 1; a_s_valid = 1; a_s_data = d;
    @(posedge clk); #1 a_start = 0;
    @(negedge clk);
    check("clear_c_rst", a_c_rst, 1);
    check("clear_c_v", a_c_v, 0);
    check("clear_busy", a_busy, 1);
    seen = 0;
    for (i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 50) a_start = 1;
      if (i == 51) a_start = 0;
      if (a_r_valid) begin
        seen = 1;
        break;
      end
    end
    check("rvalid_latency", seen ? i : -1, 245);
    a_s_valid = 0;
  endtask

  // Hold r_valid without ack, poke start, then ack together with start.
  task automatic hold_and_ack(input int exp_cnt);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 25) a_start = 1;
      if (k == 26) a_start = 0;
      check("hold_r_valid", a_r_valid, 1);
      check("hold_c_v_s_ready", {a_c_v, a_s_ready}, 0);
    end
    check("hold_sample_cnt", a_cnt, exp_cnt);
    a_r_ack = 1; a_start = 1;
    @(negedge clk);
    a_r_ack = 0; a_start = 0;
    check("ack_busy", a_busy, 0);
    check("ack_r_valid", a_r_valid, 0);
    @(negedge clk);
    check("ack_start_ignored", a_busy, 0);
  endtask

  initial begin
    int  j;
    bit  seen;
    logic [15:0] f;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_outputs", {a_s_ready, a_c_v, a_c_rst, a_busy, a_r_valid}, 0);
    check("rst_a_data", {a_c_x, a_c_y}, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_b_busy", b_busy, 0);
    rst = 0;

    // r_ack in IDLE is ignored
    @(negedge clk); a_r_ack = 1;
    @(negedge clk); a_r_ack = 0;
    check("idle_ack_busy", a_busy, 0);
    @(negedge clk);
    check("idle_ack_r_valid", a_r_valid, 0);

    // Back-to-back frame
    frame_const(16'd100);
    hold_and_ack(240);

    // Stall: s_valid toggles every cycle
    @(posedge clk); #1 a_start = 1; a_s_valid = 0;
    @(posedge clk); #1 a_start = 0;
    @(posedge clk);
    for (int k = 0; k < 240; k++) begin
      f = 16'(k * 37 - 4000);
      #1 a_s_valid = 1; a_s_data = f;
      q.push_back(f);
      if (k == 239) repeat (3) q.push_back(16'h0000);
      @(posedge clk);
      #1 a_s_valid = 0;
      @(negedge clk);
      check("stall_sample_cnt", a_cnt, k + 1);
      @(posedge clk);
    end
    seen = 0;
    for (j = 0; j < 20; j++) begin
      @(negedge clk);
      if (a_r_valid) begin
        seen = 1;
        break;
      end
    end
    check("stall_rvalid_latency", seen ? j : -1, 3);
    hold_and_ack(240);

    // Mid-frame reset after 100 samples
    for (int k = 0; k < 100; k++) q.push_back(16'd7);
    @(posedge clk); #1 a_start = 1; a_s_valid = 1; a_s_data = 16'd7;
    @(posedge clk); #1 a_start = 0;
    repeat (101) @(posedge clk);
    #1 rst = 1; a_s_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("midrst_outputs", {a_s_ready, a_c_v, a_c_rst, a_busy, a_r_valid}, 0);
    check("midrst_data", {a_c_x, a_c_y}, 0);
    check("midrst_cnt", a_cnt, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("midrst_no_rvalid", {a_r_valid, a_busy}, 0);
    end
    frame_const(16'hFFFB);
    hold_and_ack(240);

    // Boundary: FRAME_LEN=2 with extreme samples and a third offered sample
    @(posedge clk); #1 b_start = 1;
    @(posedge clk); #1 b_start = 0;
    @(posedge clk); #1 b_s_valid = 1; b_s_data = 16'h7FFF;
    @(posedge clk); #1 b_s_data = 16'h8000;
    @(negedge clk);
    check("b_beat1_c_v", b_c_v, 1);
    check("b_beat1_c_x", $signed(b_c_x), 32767);
    check("b_beat1_c_y", $signed(b_c_y), 32767);
    check("b_beat1_cnt", b_cnt, 1);
    check("b_beat1_s_ready", b_s_ready, 1);
    @(posedge clk); #1 b_s_data = 16'd1234;
    @(negedge clk);
    check("b_beat2_c_v", b_c_v, 1);
    check("b_beat2_c_x", $signed(b_c_x), -32768);
    check("b_beat2_c_y", $signed(b_c_y), -32768);
    check("b_beat2_cnt", b_cnt, 2);
    check("b_beat2_s_ready", b_s_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b_flush_c_v", b_c_v, 1);
      check("b_flush_c_x", $signed(b_c_x), 0);
      check("b_flush_cnt", b_cnt, 2);
      check("b_flush_s_ready", b_s_ready, 0);
    end
    @(negedge clk);
    b_s_valid = 0;
    check("b_done_r_valid", b_r_valid, 1);
    check("b_done_c_v", b_c_v, 0);
    b_r_ack = 1;
    @(negedge clk);
    b_r_ack = 0;
    check("b_ack_busy", b_busy, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("c_rst_pulses", n_crst, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
